// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and default
// sizing constants.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;

  localparam int DEFAULT_STABLE_COUNT = 50000;
  localparam int DEFAULT_COUNT_WIDTH  = 16;

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle for the debouncer: raw level in, filtered level and edge pulses
// out, plus the FSM state for observation.
interface input_debouncer_if;
  import debounce_pkg::*;

  // No handshake: d_in is a free-running level, asynchronous to the clock;
  // q/rise/fall are registered and valid every cycle.
  logic   d_in;
  logic   q;
  logic   rise;
  logic   fall;
  state_t dbg_state;

  modport master (output d_in, input q, rise, fall, dbg_state);
  modport slave  (input d_in, output q, rise, fall, dbg_state);

endinterface

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchroniser with asynchronous active-high clear; used wherever an
// asynchronous level enters the clock domain.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_chain: SYNC_STAGES must be 2 or more");
  end

  logic [SYNC_STAGES-1:0] r_stages;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces an asynchronous input: synchronise, then change q only after
// STABLE_COUNT consecutive differing cycles. Edge pulses need INPUT_DEBOUNCER_EDGE_PULSE_EN.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH,
  parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
  input  logic               clock,
  input  logic               reset,
  input_debouncer_if.slave   bus
);

  if (STABLE_COUNT < 1 ||
      longint'(STABLE_COUNT) > ((longint'(1) << COUNT_WIDTH) - 1)) begin : g_bad_count
    $error("input_debouncer: STABLE_COUNT out of range for COUNT_WIDTH");
  end

  // The counter holds how many differing cycles have been seen so far; the
  // cycle that would make it STABLE_COUNT is the one that flips q.
  localparam logic [COUNT_WIDTH-1:0] LP_LAST = COUNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [COUNT_WIDTH-1:0] LP_ONE  = COUNT_WIDTH'(1);

  logic                   w_sync;
  state_t                 r_state, w_state_next;
  logic [COUNT_WIDTH-1:0] r_count, w_count_next;
  logic                   r_q, w_q_next;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.d_in),
    .q     (w_sync)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= STABLE_LOW;
      r_count <= '0;
      r_q     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_q     <= w_q_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_q_next     = r_q;
    case (r_state)
      STABLE_LOW: begin
        if (w_sync) begin
          if (STABLE_COUNT == 1) begin
            w_state_next = STABLE_HIGH;
            w_q_next     = 1'b1;
            w_count_next = '0;
          end else begin
            w_state_next = WAIT_HIGH;
            w_count_next = LP_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (!w_sync) begin
          w_state_next = STABLE_LOW;
          w_count_next = '0;
        end else if (r_count == LP_LAST) begin
          w_state_next = STABLE_HIGH;
          w_q_next     = 1'b1;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + LP_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!w_sync) begin
          if (STABLE_COUNT == 1) begin
            w_state_next = STABLE_LOW;
            w_q_next     = 1'b0;
            w_count_next = '0;
          end else begin
            w_state_next = WAIT_LOW;
            w_count_next = LP_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (w_sync) begin
          w_state_next = STABLE_HIGH;
          w_count_next = '0;
        end else if (r_count == LP_LAST) begin
          w_state_next = STABLE_LOW;
          w_q_next     = 1'b0;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + LP_ONE;
        end
      end
      default: begin
        w_state_next = STABLE_LOW;
        w_q_next     = 1'b0;
        w_count_next = '0;
      end
    endcase
  end

  assign bus.q         = r_q;
  assign bus.dbg_state = r_state;

`ifdef INPUT_DEBOUNCER_EDGE_PULSE_EN
  // Pulses are registered alongside q so they line up with its change.
  logic r_rise, r_fall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_q_next & ~r_q;
      r_fall <= ~w_q_next & r_q;
    end
  end

  assign bus.rise = r_rise;
  assign bus.fall = r_fall;
`else
  assign bus.rise = 1'b0;
  assign bus.fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Randomised and directed bench for input_debouncer (SYNC_STAGES=2,
// STABLE_COUNT=4) against a sliding-window reference model.
module tb_input_debouncer;
  import debounce_pkg::*;

  localparam int SS = 2;
  localparam int SC = 4;
`ifdef INPUT_DEBOUNCER_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #10 clock = ~clock;

  input_debouncer_if bus();

  input_debouncer #(
    .SYNC_STAGES  (SS),
    .COUNT_WIDTH  (16),
    .STABLE_COUNT (SC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: d_in value taken at every sampling edge since reset.
  // The filter sees sample n-SS at edge n; q flips once the last SC seen
  // values all differ from the current q.
  bit samp_q[$];
  bit q_m, rise_m, fall_m;

  function automatic bit seen_at(int n);
    if (n - SS < 0) return 1'b0;
    return samp_q[n - SS];
  endfunction

  task automatic model_step(input bit d);
    int  n;
    bit  all_diff;
    samp_q.push_back(d);
    n        = samp_q.size() - 1;
    all_diff = 1'b1;
    for (int i = 0; i < SC; i++) begin
      if (seen_at(n - i) == q_m) all_diff = 1'b0;
    end
    rise_m = 1'b0;
    fall_m = 1'b0;
    if (all_diff) begin
      q_m    = ~q_m;
      rise_m = PULSE_EN & q_m;
      fall_m = PULSE_EN & ~q_m;
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    q_m    = 1'b0;
    rise_m = 1'b0;
    fall_m = 1'b0;
  endtask

  // Observation bookkeeping for directed timing checks.
  int edge_n = 0;
  int last_up = -1, last_dn = -1;
  int up_cnt = 0, dn_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  bit prev_q = 1'b0;

  // ---------------- driver tasks ----------------
  // Called at a negedge: drive d, take one sampling edge, check, return at negedge.
  task automatic step(input bit d);
    bus.d_in = d;
    @(posedge clock);
    model_step(d);
    edge_n++;
    #1;
    check_eq("q", 32'(bus.q), 32'(q_m));
    check_eq("rise", 32'(bus.rise), 32'(rise_m));
    check_eq("fall", 32'(bus.fall), 32'(fall_m));
    if (bus.q && !prev_q) begin up_cnt++; last_up = edge_n; end
    if (!bus.q && prev_q) begin dn_cnt++; last_dn = edge_n; end
    if (bus.rise) rise_cnt++;
    if (bus.fall) fall_cnt++;
    prev_q = bus.q;
    @(negedge clock);
  endtask

  task automatic run(input bit d, input int cycles);
    for (int i = 0; i < cycles; i++) step(d);
  endtask

  task automatic apply_reset(input int cycles, input bit d);
    reset    = 1'b1;
    bus.d_in = d;
    #1;
    check_eq("rst_q", 32'(bus.q), 32'd0);
    check_eq("rst_state", 32'(bus.dbg_state), 32'(STABLE_LOW));
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      check_eq("rst_hold_q", 32'(bus.q), 32'd0);
      check_eq("rst_hold_rise", 32'(bus.rise), 32'd0);
      check_eq("rst_hold_fall", 32'(bus.fall), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    prev_q = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int k, u0, r0, d0, f0;

  initial begin
    bus.d_in = 1'b1;
    model_reset();
    @(negedge clock);

    // 1. reset values, then release with d_in high
    apply_reset(3, 1'b1);
    k = edge_n + 1; u0 = up_cnt; r0 = rise_cnt;
    run(1'b1, 8);
    check_eq("s1_up_edge", 32'(last_up - k), 32'd5);
    check_eq("s1_up_cnt", 32'(up_cnt - u0), 32'd1);
    check_eq("s1_rise_cnt", 32'(rise_cnt - r0), 32'(PULSE_EN));

    // 2. glitch rejection from q=0
    run(1'b0, 8);
    u0 = up_cnt; r0 = rise_cnt; f0 = fall_cnt;
    run(1'b1, 3);
    run(1'b0, 6);
    check_eq("s2_no_up", 32'(up_cnt - u0), 32'd0);
    check_eq("s2_no_pulse", 32'(rise_cnt - r0 + fall_cnt - f0), 32'd0);
    check_eq("s2_state", 32'(bus.dbg_state), 32'(STABLE_LOW));

    // 3. clean press and release
    k = edge_n + 1; u0 = up_cnt; r0 = rise_cnt;
    run(1'b1, 10);
    check_eq("s3_up_edge", 32'(last_up - k), 32'd5);
    check_eq("s3_rise_cnt", 32'(rise_cnt - r0), 32'(PULSE_EN));
    k = edge_n + 1; d0 = dn_cnt; f0 = fall_cnt;
    run(1'b0, 10);
    check_eq("s3_dn_edge", 32'(last_dn - k), 32'd5);
    check_eq("s3_dn_cnt", 32'(dn_cnt - d0), 32'd1);
    check_eq("s3_fall_cnt", 32'(fall_cnt - f0), 32'(PULSE_EN));

    // 4. bounce train, then settle high
    u0 = up_cnt; d0 = dn_cnt; r0 = rise_cnt; f0 = fall_cnt;
    for (int i = 0; i < 8; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0);
    k = edge_n + 1;
    run(1'b1, 10);
    check_eq("s4_up_cnt", 32'(up_cnt - u0), 32'd1);
    check_eq("s4_dn_cnt", 32'(dn_cnt - d0), 32'd0);
    check_eq("s4_up_edge", 32'(last_up - k), 32'd5);
    check_eq("s4_pulses", 32'(rise_cnt - r0 + fall_cnt - f0), 32'(PULSE_EN));

    // 5. reset mid-count
    run(1'b0, 10);
    run(1'b1, 4);
    apply_reset(2, 1'b1);
    k = edge_n + 1;
    run(1'b1, 8);
    check_eq("s5_up_edge", 32'(last_up - k), 32'd5);

    // Random runs with occasional resets
    for (int r = 0; r < 150; r++) begin
      if ($urandom_range(0, 39) == 0) begin
        apply_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end
      run(1'($urandom_range(0, 1)), $urandom_range(1, 7));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
